rv32_w_writeback_arbiter: RTL and testbench
===========================================

RV32_W_WRITEBACK_ARBITER -- requirements
Module: rv32_w_writeback_arbiter

Interface
REQ-001 SHALL have one parameter: RR_EN, default 1, meaning 1 = round-robin between MDU and LSU, 0 = fixed priority with MDU over LSU.
REQ-002 SHALL have one clock and an asynchronous active-low reset.
REQ-003 clk_i  in  1  single clock; all state updates on posedge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 ex_valid_i  in  1  single-cycle pipeline result valid; never back-pressured.
REQ-006 ex_rd_i  in  5  pipeline destination register.
REQ-007 ex_data_i  in  32  pipeline result.
REQ-008 mdu_valid_i  in  1  multiply/divide result valid.
REQ-009 mdu_rd_i  in  5  MDU destination register.
REQ-010 mdu_data_i  in  32  MDU result.
REQ-011 mdu_ready_o  out  1  MDU holding buffer empty.
REQ-012 lsu_valid_i  in  1  load result valid.
REQ-013 lsu_rd_i  in  5  LSU destination register.
REQ-014 lsu_data_i  in  32  load data, already extended.
REQ-015 lsu_ready_o  out  1  LSU holding buffer empty.
REQ-016 write_enable_3_o  out  1  register-file write strobe.
REQ-017 write_address_3_o  out  5  register-file write address.
REQ-018 write_data_3_o  out  32  register-file write data.

Function
REQ-019 Each of MDU and LSU SHALL own a one-entry holding buffer holding a valid flag, rd and data.
REQ-020 ready_o SHALL equal NOT buffer-full, come from a flop, and have no combinational dependence on any *_valid_i.
REQ-021 A transfer SHALL occur on a posedge with valid_i=1 and ready_o=1; valid_i while ready_o=0 is ignored, and the source holds its result.
REQ-022 Grant per cycle: ex_valid_i wins unconditionally.
REQ-023 With no ex_valid_i and one buffer full, that buffer SHALL be granted.
REQ-024 With no ex_valid_i and both buffers full, RR_EN=1 SHALL grant the side named by a 1-bit pointer; RR_EN=0 SHALL grant MDU.
REQ-025 The pointer SHALL toggle only when a buffered source is granted, to the other side; it resets to MDU.
REQ-026 A granted buffer SHALL clear on the same posedge that loads the output register, and becomes refillable from the next posedge (one result per 2 cycles max per buffered source).
REQ-027 Outputs SHALL be registered: on the posedge after the grant cycle, write_enable_3_o = (granted rd != 0), with address and data from the winner.
REQ-028 With no grant, or a grant with rd = 0, the output SHALL be write_enable_3_o=0, address=0, data=0; the rd=0 entry is still consumed.
REQ-029 Latency: EX 1 cycle (sampled edge N, write visible after edge N); buffered source at least 2 cycles (accepted edge N, earliest grant edge N+1).
REQ-030 Same rd from several sources SHALL be written in grant order, with no merging or suppression.
REQ-031 Sustained ex_valid_i MAY starve both buffers indefinitely; buffers hold their contents and ready_o stays 0 meanwhile.
REQ-032 Output timing SHALL let the register file capture on the following negedge within the same cycle.

Reset
REQ-033 While rst_ni=0, write_enable_3_o, write_address_3_o and write_data_3_o SHALL be 0.
REQ-034 While rst_ni=0, both buffers SHALL be empty, mdu_ready_o=lsu_ready_o=1, and the pointer SHALL be at MDU.
REQ-035 Reset asserted mid-operation SHALL discard buffered results and any pending output immediately, without waiting for a clock edge.
REQ-036 No capture SHALL occur on any posedge while rst_ni=0.

Verification
REQ-037 ex_valid_i=1, rd=5, data=0xDEADBEEF at edge N -> after edge N: we=1, addr=5, data=0xDEADBEEF; after edge N+1: we=0, addr=0, data=0.
REQ-038 MDU rd=3/0x11 and LSU rd=4/0x22 accepted at the same edge, RR_EN=1, no EX -> writes rd=3 then rd=4 on consecutive cycles; both ready_o return to 1 afterward.
REQ-039 Both buffers full, ex_valid_i held 3 cycles -> three EX writes; ready_o stays 0 throughout; buffered writes follow in pointer order.
REQ-040 LSU rd=0, data=0x55 -> LSU buffer cleared, write_enable_3_o stays 0, lsu_ready_o returns to 1.
REQ-041 rst_ni pulled low between edges with both buffers full -> outputs 0 immediately; after release, no stale write ever appears and both ready_o=1.
REQ-042 RR_EN=0, MDU and LSU refilled each time they are freed, no EX -> only MDU granted while both are full; LSU is granted only on cycles when the MDU buffer is empty.

Source files
------------

// File: rtl/rv32_w_writeback_arbiter_if.sv
//------------------------------------------------------------------------------
// rv32_w_writeback_arbiter_if
//
// Purpose:
//   Bundles the three result sources of the writeback stage and the single
//   register-file write port that they compete for.
//
// Signal summary:
//   ex_valid_i/ex_rd_i/ex_data_i        single-cycle pipeline result; it never
//                                       stalls, so it has no ready
//   mdu_valid_i/mdu_rd_i/mdu_data_i     multiply/divide result
//   mdu_ready_o                         MDU holding buffer can take a result
//   lsu_valid_i/lsu_rd_i/lsu_data_i     load result, already extended
//   lsu_ready_o                         LSU holding buffer can take a result
//   write_enable_3_o                    register-file write strobe
//   write_address_3_o                   register-file write address
//   write_data_3_o                      register-file write data
//
// Modports:
//   slave  - the arbiter: consumes results, drives readies and the write port
//   master - the result producers and register file seen from the outside
//------------------------------------------------------------------------------
interface rv32_w_writeback_arbiter_if;

   // Pipeline (EX) result
   logic        ex_valid_i;
   logic [4:0]  ex_rd_i;
   logic [31:0] ex_data_i;

   // Multiply/divide unit result and its handshake
   logic        mdu_valid_i;
   logic [4:0]  mdu_rd_i;
   logic [31:0] mdu_data_i;
   logic        mdu_ready_o;

   // Load/store unit result and its handshake
   logic        lsu_valid_i;
   logic [4:0]  lsu_rd_i;
   logic [31:0] lsu_data_i;
   logic        lsu_ready_o;

   // Register-file write port
   logic        write_enable_3_o;
   logic [4:0]  write_address_3_o;
   logic [31:0] write_data_3_o;

   modport slave (
      input  ex_valid_i,
      input  ex_rd_i,
      input  ex_data_i,
      input  mdu_valid_i,
      input  mdu_rd_i,
      input  mdu_data_i,
      output mdu_ready_o,
      input  lsu_valid_i,
      input  lsu_rd_i,
      input  lsu_data_i,
      output lsu_ready_o,
      output write_enable_3_o,
      output write_address_3_o,
      output write_data_3_o
   );

   modport master (
      output ex_valid_i,
      output ex_rd_i,
      output ex_data_i,
      output mdu_valid_i,
      output mdu_rd_i,
      output mdu_data_i,
      input  mdu_ready_o,
      output lsu_valid_i,
      output lsu_rd_i,
      output lsu_data_i,
      input  lsu_ready_o,
      input  write_enable_3_o,
      input  write_address_3_o,
      input  write_data_3_o
   );

endinterface

// File: rtl/rv32_w_writeback_arbiter.sv
//------------------------------------------------------------------------------
// rv32_w_writeback_arbiter
//
// Purpose:
//   Merges three result streams onto one register-file write port.
//   The EX pipeline result is never stalled and always wins. The MDU and LSU
//   each park a result in a one-entry holding buffer and are served whenever
//   EX is idle. When both buffers are full the choice is either round-robin
//   (RR_EN=1) or fixed with MDU first (RR_EN=0).
//
// Parameters:
//   RR_EN   1 = round-robin between MDU and LSU, 0 = MDU always beats LSU
//
// Ports:
//   clk_i   single clock, all state updates on the rising edge
//   rst_ni  asynchronous active-low reset
//   wb      rv32_w_writeback_arbiter_if.slave, result inputs, buffer readies
//           and the registered register-file write port
//
// Timing:
//   EX result sampled on edge N is written after edge N.
//   A buffered result accepted on edge N is granted at the earliest in the
//   cycle that ends with edge N+1 and is written after that edge.
//   The write port is driven straight from flops so the register file can
//   capture it on the following falling edge.
//------------------------------------------------------------------------------
module rv32_w_writeback_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input logic                        clk_i,
   input logic                        rst_ni,
   rv32_w_writeback_arbiter_if.slave  wb
);

   // Which source owns the write port in the current cycle
   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_EX,
      GRANT_MDU,
      GRANT_LSU
   } grant_e;

   // MDU holding buffer
   logic        mdu_full_q;
   logic [4:0]  mdu_rd_q;
   logic [31:0] mdu_data_q;

   // LSU holding buffer
   logic        lsu_full_q;
   logic [4:0]  lsu_rd_q;
   logic [31:0] lsu_data_q;

   // Round-robin pointer: 0 = MDU goes next, 1 = LSU goes next
   logic        ptr_lsu_q;

   // Arbitration results
   grant_e      grant;
   logic        mdu_accept;
   logic        lsu_accept;
   logic        win_valid;
   logic [4:0]  win_rd;
   logic [31:0] win_data;

   // Next values of the registered write port
   logic        we_d;
   logic [4:0]  addr_d;
   logic [31:0] data_d;

   // Registered write port
   logic        we_q;
   logic [4:0]  addr_q;
   logic [31:0] data_q;

   // A buffer only takes a new result while it is empty. Because a granted
   // buffer is full by definition, accepting and draining never happen on the
   // same edge: a drained buffer becomes refillable one edge later.
   assign mdu_accept = wb.mdu_valid_i && !mdu_full_q;
   assign lsu_accept = wb.lsu_valid_i && !lsu_full_q;

   // Ready is purely a function of buffer occupancy held in a flop, so the
   // producers never see a combinational path from their own valid.
   assign wb.mdu_ready_o = !mdu_full_q;
   assign wb.lsu_ready_o = !lsu_full_q;

   // Pick the owner of the write port for this cycle. EX cannot be stalled
   // and so always wins; the buffers only compete among themselves.
   always_comb begin
      grant = GRANT_NONE;
      if (wb.ex_valid_i) begin
         grant = GRANT_EX;
      end else if (mdu_full_q && lsu_full_q) begin
         if (RR_EN && ptr_lsu_q) begin
            grant = GRANT_LSU;
         end else begin
            grant = GRANT_MDU;
         end
      end else if (mdu_full_q) begin
         grant = GRANT_MDU;
      end else if (lsu_full_q) begin
         grant = GRANT_LSU;
      end
   end

   // Route the winner's destination and data to the write-port staging logic
   always_comb begin
      win_valid = 1'b0;
      win_rd    = 5'd0;
      win_data  = 32'd0;
      case (grant)
         GRANT_EX: begin
            win_valid = 1'b1;
            win_rd    = wb.ex_rd_i;
            win_data  = wb.ex_data_i;
         end
         GRANT_MDU: begin
            win_valid = 1'b1;
            win_rd    = mdu_rd_q;
            win_data  = mdu_data_q;
         end
         GRANT_LSU: begin
            win_valid = 1'b1;
            win_rd    = lsu_rd_q;
            win_data  = lsu_data_q;
         end
         default: begin
            win_valid = 1'b0;
            win_rd    = 5'd0;
            win_data  = 32'd0;
         end
      endcase
   end

   // x0 is hard-wired to zero, so a result aimed at it is consumed but never
   // written. An idle port is driven to all zeros rather than holding stale
   // address/data.
   always_comb begin
      we_d   = win_valid && (win_rd != 5'd0);
      addr_d = 5'd0;
      data_d = 32'd0;
      if (we_d) begin
         addr_d = win_rd;
         data_d = win_data;
      end
   end

   // MDU holding buffer: fill when empty, drain when granted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mdu_full_q <= 1'b0;
         mdu_rd_q   <= 5'd0;
         mdu_data_q <= 32'd0;
      end else if (mdu_accept) begin
         mdu_full_q <= 1'b1;
         mdu_rd_q   <= wb.mdu_rd_i;
         mdu_data_q <= wb.mdu_data_i;
      end else if (grant == GRANT_MDU) begin
         mdu_full_q <= 1'b0;
      end
   end

   // LSU holding buffer: fill when empty, drain when granted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lsu_full_q <= 1'b0;
         lsu_rd_q   <= 5'd0;
         lsu_data_q <= 32'd0;
      end else if (lsu_accept) begin
         lsu_full_q <= 1'b1;
         lsu_rd_q   <= wb.lsu_rd_i;
         lsu_data_q <= wb.lsu_data_i;
      end else if (grant == GRANT_LSU) begin
         lsu_full_q <= 1'b0;
      end
   end

   // The pointer moves only when a buffered source is served, and always
   // points at the side that was not just served. An EX win leaves it alone,
   // so a long EX burst does not disturb the buffered ordering.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_lsu_q <= 1'b0;
      end else if (grant == GRANT_MDU) begin
         ptr_lsu_q <= 1'b1;
      end else if (grant == GRANT_LSU) begin
         ptr_lsu_q <= 1'b0;
      end
   end

   // Registered write port; the asynchronous clear drops any pending write
   // the moment reset is asserted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q   <= 1'b0;
         addr_q <= 5'd0;
         data_q <= 32'd0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign wb.write_enable_3_o  = we_q;
   assign wb.write_address_3_o = addr_q;
   assign wb.write_data_3_o    = data_q;

endmodule

// File: tb/tb_rv32_w_writeback_arbiter.sv
//------------------------------------------------------------------------------
// tb_rv32_w_writeback_arbiter
//
// Drives one round-robin and one fixed-priority arbiter with identical input
// streams. A reference model predicts, per cycle, what each register-file
// port shows after the next rising edge; predictions are queued and a
// separate monitor compares them against the DUTs.
//------------------------------------------------------------------------------
module tb_rv32_w_writeback_arbiter;

   logic clk = 1'b0;
   logic rst_n;

   // Shared stimulus, fanned out to both DUTs
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_data;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;

   int checks = 0;
   int errors = 0;

   // What one port should show after a rising edge
   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        mdu_ready;
      logic        lsu_ready;
   } exp_t;

   // A parked result in the reference model
   typedef struct {
      bit          full;
      logic [4:0]  rd;
      logic [31:0] data;
   } slot_t;

   // Index 0 models the round-robin DUT, index 1 the fixed-priority DUT
   slot_t m_mdu[2];
   slot_t m_lsu[2];
   bit    m_next_lsu[2];

   exp_t q_rr[$];
   exp_t q_fp[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   rv32_w_writeback_arbiter_if wb_rr();
   rv32_w_writeback_arbiter_if wb_fp();

   assign wb_rr.ex_valid_i  = ex_valid;
   assign wb_rr.ex_rd_i     = ex_rd;
   assign wb_rr.ex_data_i   = ex_data;
   assign wb_rr.mdu_valid_i = mdu_valid;
   assign wb_rr.mdu_rd_i    = mdu_rd;
   assign wb_rr.mdu_data_i  = mdu_data;
   assign wb_rr.lsu_valid_i = lsu_valid;
   assign wb_rr.lsu_rd_i    = lsu_rd;
   assign wb_rr.lsu_data_i  = lsu_data;

   assign wb_fp.ex_valid_i  = ex_valid;
   assign wb_fp.ex_rd_i     = ex_rd;
   assign wb_fp.ex_data_i   = ex_data;
   assign wb_fp.mdu_valid_i = mdu_valid;
   assign wb_fp.mdu_rd_i    = mdu_rd;
   assign wb_fp.mdu_data_i  = mdu_data;
   assign wb_fp.lsu_valid_i = lsu_valid;
   assign wb_fp.lsu_rd_i    = lsu_rd;
   assign wb_fp.lsu_data_i  = lsu_data;

   rv32_w_writeback_arbiter #(.RR_EN(1'b1)) dut_rr (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .wb     (wb_rr)
   );

   rv32_w_writeback_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .wb     (wb_fp)
   );

   // Single comparison point; every check goes through here
   task automatic check_value(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic check_output(input string tag, input exp_t e,
                               input logic we, input logic [4:0] addr,
                               input logic [31:0] data,
                               input logic mr, input logic lr);
      check_value({tag, ".we"},        {31'd0, we},   {31'd0, e.we});
      check_value({tag, ".addr"},      {27'd0, addr}, {27'd0, e.addr});
      check_value({tag, ".data"},      data,          e.data);
      check_value({tag, ".mdu_ready"}, {31'd0, mr},   {31'd0, e.mdu_ready});
      check_value({tag, ".lsu_ready"}, {31'd0, lr},   {31'd0, e.lsu_ready});
   endtask

   // Reset forces an idle write port and two empty buffers on both DUTs
   task automatic check_reset_outputs(input string tag);
      exp_t idle;
      idle.we = 1'b0; idle.addr = 5'd0; idle.data = 32'd0;
      idle.mdu_ready = 1'b1; idle.lsu_ready = 1'b1;
      check_output({tag, ".rr"}, idle, wb_rr.write_enable_3_o, wb_rr.write_address_3_o,
                   wb_rr.write_data_3_o, wb_rr.mdu_ready_o, wb_rr.lsu_ready_o);
      check_output({tag, ".fp"}, idle, wb_fp.write_enable_3_o, wb_fp.write_address_3_o,
                   wb_fp.write_data_3_o, wb_fp.mdu_ready_o, wb_fp.lsu_ready_o);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_mdu[i].full = 1'b0; m_mdu[i].rd = 5'd0; m_mdu[i].data = 32'd0;
         m_lsu[i].full = 1'b0; m_lsu[i].rd = 5'd0; m_lsu[i].data = 32'd0;
         m_next_lsu[i] = 1'b0;
      end
   endtask

   // One cycle of the writeback rules: who writes, who drains, who fills
   task automatic model_step(input int idx, input bit rr, output exp_t e);
      slot_t      mdu;
      slot_t      lsu;
      bit         served;
      logic [4:0] rd;
      logic [31:0] data;
      mdu = m_mdu[idx];
      lsu = m_lsu[idx];
      served = 1'b0;
      rd = 5'd0;
      data = 32'd0;
      if (ex_valid) begin
         served = 1'b1; rd = ex_rd; data = ex_data;
      end else if (mdu.full && (!lsu.full || !rr || !m_next_lsu[idx])) begin
         served = 1'b1; rd = mdu.rd; data = mdu.data;
         m_mdu[idx].full = 1'b0;
         m_next_lsu[idx] = 1'b1;
      end else if (lsu.full) begin
         served = 1'b1; rd = lsu.rd; data = lsu.data;
         m_lsu[idx].full = 1'b0;
         m_next_lsu[idx] = 1'b0;
      end
      // Offers are judged against occupancy before this edge
      if (mdu_valid && !mdu.full) begin
         m_mdu[idx].full = 1'b1; m_mdu[idx].rd = mdu_rd; m_mdu[idx].data = mdu_data;
      end
      if (lsu_valid && !lsu.full) begin
         m_lsu[idx].full = 1'b1; m_lsu[idx].rd = lsu_rd; m_lsu[idx].data = lsu_data;
      end
      e.we        = served && (rd != 5'd0);
      e.addr      = e.we ? rd : 5'd0;
      e.data      = e.we ? data : 32'd0;
      e.mdu_ready = !m_mdu[idx].full;
      e.lsu_ready = !m_lsu[idx].full;
   endtask

   // Called at a falling edge: drive one cycle, queue predictions, wait a cycle
   task automatic apply_stimulus(input bit exv, input logic [4:0] exr, input logic [31:0] exd,
                                 input bit mv, input logic [4:0] mr, input logic [31:0] md,
                                 input bit lv, input logic [4:0] lr, input logic [31:0] ld);
      exp_t e;
      ex_valid = exv;  ex_rd = exr;  ex_data = exd;
      mdu_valid = mv;  mdu_rd = mr;  mdu_data = md;
      lsu_valid = lv;  lsu_rd = lr;  lsu_data = ld;
      model_step(0, 1'b1, e);
      q_rr.push_back(e);
      model_step(1, 1'b0, e);
      q_fp.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Assert reset between edges, check the immediate clear, hold it across
   // edges with busy inputs, then release on a falling edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_async");
      q_rr.delete();
      q_fp.delete();
      model_clear();
      ex_valid = 1'b1;  ex_rd = 5'd9;   ex_data = 32'hA5A5_0001;
      mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hA5A5_0002;
      lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hA5A5_0003;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_reset_outputs("reset_hold");
      end
      @(negedge clk);
      ex_valid = 1'b0;  ex_rd = 5'd0;  ex_data = 32'd0;
      mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
      rst_n = 1'b1;
   endtask

   function automatic logic [4:0] rand_rd();
      if ($urandom_range(0, 7) == 0) return 5'd0;
      return 5'($urandom_range(1, 31));
   endfunction

   // Monitor: one queued prediction per port per rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q_rr.size() > 0) begin
            mon_e = q_rr.pop_front();
            check_output("rr", mon_e, wb_rr.write_enable_3_o, wb_rr.write_address_3_o,
                         wb_rr.write_data_3_o, wb_rr.mdu_ready_o, wb_rr.lsu_ready_o);
         end
         if (q_fp.size() > 0) begin
            mon_e = q_fp.pop_front();
            check_output("fp", mon_e, wb_fp.write_enable_3_o, wb_fp.write_address_3_o,
                         wb_fp.write_data_3_o, wb_fp.mdu_ready_o, wb_fp.lsu_ready_o);
         end
      end
   end

   // Watchdog so the run always ends with a summary
   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      model_clear();
      do_reset();

      // Single EX write, then the port returns to idle
      apply_stimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      idle(2);

      // MDU and LSU accepted together drain on consecutive cycles
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
      idle(3);

      // EX burst starves two full buffers; late offers must be ignored
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h200);
      apply_stimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'h101, 1'b1, 5'd13, 32'h201);
      apply_stimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'h101, 1'b1, 5'd13, 32'h201);
      apply_stimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'h101, 1'b1, 5'd13, 32'h201);
      idle(4);

      // A load to x0 is consumed without a write
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
      idle(3);

      // Reset mid-operation with both buffers full and a write pending
      apply_stimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
      do_reset();
      idle(4);

      // Both sources refill whenever freed, no EX: ordering differs by mode
      for (int i = 0; i < 12; i++)
         apply_stimulus(1'b0, 5'd0, 32'd0,
                        1'b1, 5'(16 + i), 32'h1000 + 32'(i),
                        1'b1, 5'(2 + i), 32'h2000 + 32'(i));
      idle(4);

      // Randomized traffic with one reset dropped in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         apply_stimulus($urandom_range(0, 9) < 3, rand_rd(), $urandom(),
                        $urandom_range(0, 1) == 1, rand_rd(), $urandom(),
                        $urandom_range(0, 1) == 1, rand_rd(), $urandom());
      end
      idle(4);

      check_value("queue_drain", 32'(q_rr.size() + q_fp.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
